// File: rtl/b06_pkg.sv
// Shared encodings for the b06 interrupt-handshake controller and its requester peer.
// Controller codes are 2-bit (cc_mux, uscite) pairs; peer states are the requester FSM.
package b06_pkg;

  typedef enum logic [2:0] {
    s_init, s_wait, s_enin, s_enin_w, s_intr, s_intr_1, s_intr_w
  } ctl_state_t;

  localparam logic [1:0] cc_nop     = 2'b01;
  localparam logic [1:0] cc_enin    = 2'b01;
  localparam logic [1:0] cc_intr    = 2'b10;
  localparam logic [1:0] cc_ackin   = 2'b11;
  localparam logic [1:0] out_ack    = 2'b00;
  localparam logic [1:0] out_norm   = 2'b01;
  localparam logic [1:0] out_intr_w = 2'b11;

  typedef enum logic [1:0] {P_IDLE, P_REQ, P_HOLD, P_REL} peer_state_t;

  typedef struct packed {
    logic [1:0] cc_mux;
    logic [1:0] uscite;
  } ctl_code_t;

  function automatic logic code_is(input ctl_code_t c, input logic [1:0] cc, input logic [1:0] us);
    return (c.cc_mux == cc) && (c.uscite == us);
  endfunction

endpackage

// File: rtl/b06_cont_cmp.sv
// Free-running enable counter with a registered equality flag against cmp_val.
// One cycle from cnt to cont_eql; no backpressure, wraps silently.
module b06_cont_cmp
  import b06_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_count,
  input  logic [CNT_W-1:0] cmp_val,
  output logic             cont_eql
);

  logic [CNT_W-1:0] cnt;

  // The flag compares the pre-increment count, so it trails cnt by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      cont_eql <= 1'b0;
    end else begin
      cont_eql <= (cnt == cmp_val);
      if (enable_count) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/b06_peer.sv
// Requester opposite the b06 controller: raises eql, holds it after ack, waits for release, times out.
// Outputs registered; req_start ignored while busy or on the req_done cycle. Option: B06_PEER_ACKCHK_EN.
module b06_peer
  import b06_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int HOLD_CYC = 3,
  parameter int TMO_CYC  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       cc_mux,
  input  logic [1:0]       uscite,
  input  logic             enable_count,
  input  logic             ackout,
  input  logic             req_start,
  input  logic [CNT_W-1:0] cmp_val,
  output logic             eql,
  output logic             cont_eql,
  output logic             busy,
  output logic             req_done,
  output logic             grant_intr,
  output logic             err
);

  peer_state_t state;
  ctl_code_t   code;
  logic [3:0]  hold_cnt;
  logic [7:0]  tmo_cnt;
  logic        ack_seen, rel_enin, rel_intr, tmo_hit, fsm_err;

  assign code     = '{cc_mux: cc_mux, uscite: uscite};
  assign ack_seen = code_is(code, cc_ackin, out_ack);
  assign rel_enin = code_is(code, cc_enin, out_norm);
  assign rel_intr = code_is(code, cc_intr, out_intr_w);
  assign tmo_hit  = (tmo_cnt == 8'(TMO_CYC - 1));
  assign busy     = (state != P_IDLE);

  b06_cont_cmp #(.CNT_W(CNT_W)) u_cont_cmp (
    .clock        (clock),
    .reset        (reset),
    .enable_count (enable_count),
    .cmp_val      (cmp_val),
    .cont_eql     (cont_eql)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= P_IDLE;
      eql        <= 1'b0;
      req_done   <= 1'b0;
      grant_intr <= 1'b0;
      fsm_err    <= 1'b0;
      hold_cnt   <= '0;
      tmo_cnt    <= '0;
    end else begin
      req_done   <= 1'b0;
      grant_intr <= 1'b0;
      fsm_err    <= 1'b0;
      case (state)
        P_IDLE: begin
          if (req_start && !req_done) begin
            eql     <= 1'b1;
            tmo_cnt <= '0;
            state   <= P_REQ;
          end
        end
        // Ack is tested first so it wins over a coincident timeout.
        P_REQ: begin
          if (ack_seen) begin
            hold_cnt <= 4'(HOLD_CYC - 1);
            state    <= P_HOLD;
          end else if (tmo_hit) begin
            eql     <= 1'b0;
            fsm_err <= 1'b1;
            state   <= P_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        P_HOLD: begin
          if (hold_cnt == '0) begin
            eql   <= 1'b0;
            state <= P_REL;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        P_REL: begin
          if (rel_enin) begin
            req_done <= 1'b1;
            state    <= P_IDLE;
          end else if (rel_intr) begin
            req_done   <= 1'b1;
            grant_intr <= 1'b1;
            state      <= P_IDLE;
          end
        end
        default: state <= P_IDLE;
      endcase
    end
  end

`ifdef B06_PEER_ACKCHK_EN
  logic armed, cont_eql_q, chk_err, done_next;

  assign done_next = (state == P_REL) && (rel_enin || rel_intr);

  // Checker stays quiet for the first cycle out of reset and never overlaps req_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed      <= 1'b0;
      cont_eql_q <= 1'b0;
      chk_err    <= 1'b0;
    end else begin
      armed      <= 1'b1;
      cont_eql_q <= cont_eql;
      chk_err    <= armed && !done_next &&
                    ((enable_count != ackout) || (!cont_eql_q && !ackout));
    end
  end

  assign err = fsm_err | chk_err;
`else
  logic unused_ackout;
  assign unused_ackout = ackout;
  assign err = fsm_err;
`endif

endmodule
